// File: rtl/riscv_hwloop_sequencer.sv
// riscv_hwloop_sequencer: hwloop end detection, fetch jump request and one-hot decrement sequencing.
// Define RISCV_HWLP_JUMP_STATS_EN to add the saturating jump handshake counter hwlp_jump_count_o.
module riscv_hwloop_sequencer #(
  parameter int N_REGS     = 2,
  parameter int N_REG_BITS = $clog2(N_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           pc_i,
  input  logic                  pc_valid_i,
  input  logic [31:0]           hwlp_start_addr_i [N_REGS],
  input  logic [31:0]           hwlp_end_addr_i   [N_REGS],
  input  logic [31:0]           hwlp_counter_i    [N_REGS],
  input  logic [2:0]            hwlp_we_i,
  input  logic [N_REG_BITS-1:0] hwlp_regid_i,
  input  logic                  valid_i,
  input  logic                  kill_i,
  output logic                  jump_req_o,
  output logic [31:0]           jump_target_o,
  input  logic                  jump_ack_i,
  output logic [N_REGS-1:0]     hwlp_dec_cnt_o,
  output logic                  busy_o
`ifdef RISCV_HWLP_JUMP_STATS_EN
  , output logic [31:0]         hwlp_jump_count_o
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] JUMP = 1'b1;
  logic [0:0]            state;
  logic [N_REG_BITS-1:0] sel, hit_sel;
  logic                  dec_pending, hit, take;
  logic                  unused_we;
  assign unused_we = ^hwlp_we_i[1:0];
  // Descending scan so the lowest (innermost) matching loop wins.
  always_comb begin
    hit = 1'b0;
    hit_sel = '0;
    for (int k = N_REGS - 1; k >= 0; k--)
      if (pc_valid_i && pc_i == hwlp_end_addr_i[k] && hwlp_counter_i[k] != 32'd0) begin
        hit = 1'b1;
        hit_sel = N_REG_BITS'(k);
      end
  end
  assign take = hit && state == IDLE && !dec_pending;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      dec_pending <= 1'b0;
      jump_target_o <= '0;
    end else if (kill_i) begin
      state <= IDLE;
      dec_pending <= 1'b0;
    end else if (take) begin
      sel <= hit_sel;
      dec_pending <= 1'b1;
      if (hwlp_counter_i[hit_sel] > 32'd1) begin
        state <= JUMP;
        jump_target_o <= hwlp_start_addr_i[hit_sel];
      end
    end else begin
      if (state == JUMP && jump_ack_i) state <= IDLE;
      // A counter write to the selected loop overrides the pending decrement in the register file.
      if (dec_pending && (valid_i || (hwlp_we_i[2] && hwlp_regid_i == sel))) dec_pending <= 1'b0;
    end
  assign jump_req_o     = state == JUMP;
  assign hwlp_dec_cnt_o = dec_pending ? N_REGS'(1) << sel : '0;
  assign busy_o         = state != IDLE || dec_pending;
`ifdef RISCV_HWLP_JUMP_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hwlp_jump_count_o <= '0;
    else if (jump_req_o && jump_ack_i && hwlp_jump_count_o != '1) hwlp_jump_count_o <= hwlp_jump_count_o + 32'd1;
`endif
endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// tb_riscv_hwloop_sequencer: directed bench with a small hwloop register file around the sequencer.
module tb_riscv_hwloop_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, pc_valid, valid, kill, ack, regid;
  logic [31:0] pc, w_start, w_end, w_cnt, tgt;
  logic [31:0] r_start [2], r_end [2], r_cnt [2];
  logic [2:0]  we;
  logic        jump_req, busy;
  logic [1:0]  dec;
  int          errors = 0, checks = 0;
`ifdef RISCV_HWLP_JUMP_STATS_EN
  logic [31:0] jcount;
`endif
  always #5 clk = ~clk;
  riscv_hwloop_sequencer dut (
    .clk(clk), .rst_n(rst_n), .pc_i(pc), .pc_valid_i(pc_valid),
    .hwlp_start_addr_i(r_start), .hwlp_end_addr_i(r_end), .hwlp_counter_i(r_cnt),
    .hwlp_we_i(we), .hwlp_regid_i(regid), .valid_i(valid), .kill_i(kill),
    .jump_req_o(jump_req), .jump_target_o(tgt), .jump_ack_i(ack),
    .hwlp_dec_cnt_o(dec), .busy_o(busy)
`ifdef RISCV_HWLP_JUMP_STATS_EN
    , .hwlp_jump_count_o(jcount)
`endif
  );
  // Register file: a counter write beats a same-cycle decrement.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        r_start[k] <= '0;
        r_end[k] <= '0;
        r_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (we[0] && regid == 1'(k)) r_start[k] <= w_start;
        if (we[1] && regid == 1'(k)) r_end[k] <= w_end;
        if (we[2] && regid == 1'(k)) r_cnt[k] <= w_cnt;
        else if (valid && dec[k]) r_cnt[k] <= r_cnt[k] - 32'd1;
      end
    end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_o(input string tag, input logic e_req, input logic [31:0] e_tgt, input logic [1:0] e_dec, input logic e_busy);
    chk({tag, ".req"}, {31'd0, jump_req}, {31'd0, e_req});
    if (e_req) chk({tag, ".tgt"}, tgt, e_tgt);
    chk({tag, ".dec"}, {30'd0, dec}, {30'd0, e_dec});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
  endtask
  task automatic cfg(input logic id, input logic [31:0] s, input logic [31:0] e, input logic [31:0] c);
    we = 3'b111;
    regid = id;
    w_start = s;
    w_end = e;
    w_cnt = c;
    tick;
    we = 3'b000;
  endtask
  task automatic accept(input logic [31:0] a);
    pc = a;
    pc_valid = 1'b1;
    tick;
    pc_valid = 1'b0;
  endtask
  task automatic retire;
    valid = 1'b1;
    tick;
    valid = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; pc = '0; pc_valid = 1'b0; valid = 1'b0; kill = 1'b0; ack = 1'b0;
    we = '0; regid = 1'b0; w_start = '0; w_end = '0; w_cnt = '0;
    #2;
    chk("rst.tgt", tgt, 32'h0);
    chk_o("rst", 1'b0, 32'h0, 2'b00, 1'b0);
    #10 rst_n = 1'b1;
    tick;
    cfg(1'b0, 32'h100, 32'h10C, 32'd3);
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept(32'h10C);
      chk_o($sformatf("s1_hit%0d", i), i < 2, 32'h100, 2'b01, 1'b1);
      retire;
      chk_o($sformatf("s1_ret%0d", i), 1'b0, 32'h0, 2'b00, 1'b0);
      chk($sformatf("s1_cnt%0d", i), r_cnt[0], 32'(2 - i));
    end
    accept(32'h10C);
    chk_o("s1_dead", 1'b0, 32'h0, 2'b00, 1'b0);
    cfg(1'b0, 32'h200, 32'h120, 32'd2);
    cfg(1'b1, 32'h300, 32'h120, 32'd5);
    accept(32'h120);
    chk_o("s2_nest", 1'b1, 32'h200, 2'b01, 1'b1);
    retire;
    chk("s2_cnt0", r_cnt[0], 32'd1);
    chk("s2_cnt1", r_cnt[1], 32'd5);
    accept(32'h120);
    chk_o("s2_last", 1'b0, 32'h0, 2'b01, 1'b1);
    retire;
    chk("s2_cnt0z", r_cnt[0], 32'd0);
    accept(32'h120);
    chk_o("s2_inner", 1'b1, 32'h300, 2'b10, 1'b1);
    retire;
    chk_o("s2_idle", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("s2_cnt1d", r_cnt[1], 32'd4);
    ack = 1'b0;
    accept(32'h120);
    for (int i = 0; i < 4; i++) begin
      chk_o($sformatf("s3_wait%0d", i), 1'b1, 32'h300, 2'b10, 1'b1);
      if (i == 1) begin
        we = 3'b001;
        regid = 1'b1;
        w_start = 32'hDEAD0;
      end
      tick;
      we = 3'b000;
    end
    ack = 1'b1;
    chk_o("s3_ackcyc", 1'b1, 32'h300, 2'b10, 1'b1);
    tick;
    chk_o("s3_acked", 1'b0, 32'h0, 2'b10, 1'b1);
    retire;
    chk_o("s3_idle", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("s3_cnt1", r_cnt[1], 32'd3);
    cfg(1'b0, 32'h100, 32'h10C, 32'd3);
    ack = 1'b0;
    accept(32'h10C);
    chk_o("s4_jump", 1'b1, 32'h100, 2'b01, 1'b1);
    kill = 1'b1;
    tick;
    kill = 1'b0;
    chk_o("s4_kill", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("s4_cnt0", r_cnt[0], 32'd3);
    ack = 1'b1;
    accept(32'h10C);
    chk_o("s5_hit", 1'b1, 32'h100, 2'b01, 1'b1);
    we = 3'b100;
    regid = 1'b0;
    w_cnt = 32'd10;
    tick;
    we = 3'b000;
    chk_o("s5_wr", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("s5_cnt0", r_cnt[0], 32'd10);
    ack = 1'b0;
    accept(32'h10C);
    chk_o("s6_jump", 1'b1, 32'h100, 2'b01, 1'b1);
    kill = 1'b1;
    valid = 1'b1;
    tick;
    kill = 1'b0;
    valid = 1'b0;
    chk_o("s6_killret", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("s6_cnt0", r_cnt[0], 32'd9);
    ack = 1'b1;
    accept(32'h10C);
    kill = 1'b1;
    tick;
    kill = 1'b0;
    chk_o("s7_killack", 1'b0, 32'h0, 2'b00, 1'b0);
    chk("s7_cnt0", r_cnt[0], 32'd9);
    ack = 1'b0;
    accept(32'h10C);
    chk_o("s8_jump", 1'b1, 32'h100, 2'b01, 1'b1);
`ifdef RISCV_HWLP_JUMP_STATS_EN
    chk("s8_count", jcount, 32'd7);
`endif
    #3 rst_n = 1'b0;
    #1;
    chk("s8_rst.tgt", tgt, 32'h0);
    chk_o("s8_rst", 1'b0, 32'h0, 2'b00, 1'b0);
`ifdef RISCV_HWLP_JUMP_STATS_EN
    chk("s8_rst.count", jcount, 32'd0);
`endif
    #2 rst_n = 1'b1;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
